// File: rtl/ikbd_host_acia_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ikbd_host_acia_pkg
//  Description : Shared constants and state encodings for the host-side
//                6850-style ACIA (register selects, status/control bit
//                positions, rx/tx state machine encodings).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package ikbd_host_acia_pkg;

    // Register select values on the rs pin
    localparam logic CTRL_STAT = 1'b0;
    localparam logic DATA      = 1'b1;

    // Status register bit positions
    localparam int SR_RDRF = 0;
    localparam int SR_TDRE = 1;
    localparam int SR_DCD  = 2;
    localparam int SR_CTS  = 3;
    localparam int SR_FE   = 4;
    localparam int SR_OVRN = 5;
    localparam int SR_PE   = 6;
    localparam int SR_IRQ  = 7;

    // Control register fields
    localparam int CR_CDS_LSB = 0;   // [1:0] counter divide select
    localparam int CR_WS_LSB  = 2;   // [4:2] word select
    localparam int CR_TC_LSB  = 5;   // [6:5] transmit control
    localparam int CR_RIE     = 7;   // receive interrupt enable

    localparam logic [1:0] CDS_MASTER_RESET = 2'b11;
    localparam logic [2:0] WS_TWO_STOP      = 3'b100;
    localparam logic [1:0] TC_TIE_ON        = 2'b01;
    localparam logic [1:0] TC_RTS_HIGH      = 2'b10;
    localparam logic [1:0] TC_BREAK         = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP1 = 3'd3,
        TX_STOP2 = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/ikbd_acia_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ikbd_acia_rx
//  Description : 8N1 serial receiver. Two-flop synchroniser, falling-edge
//                start detection, half-bit start validation, mid-bit data
//                sampling (LSB first) and a single stop-bit sample.
//  Ports       : clk, rst_n      - clock / async active-low reset
//                enable          - low forces the FSM idle (aborts a frame)
//                rxd             - asynchronous serial input, idle high
//                byte_valid      - one-cycle pulse at the stop-bit sample
//                data            - received byte, valid with byte_valid
//                stop_ok         - sampled stop bit, valid with byte_valid
//  Revision    : 1.0  initial release
// ============================================================================
module ikbd_acia_rx
    import ikbd_host_acia_pkg::*;
#(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       stop_ok
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; a high level means noise.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                // Returning to idle mid stop bit lets the next start edge
                // be caught without waiting for the bit to end.
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    byte_valid = 1'b1;
                    state_d    = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (!enable) begin
            state_d    = RX_IDLE;
            cnt_d      = '0;
            byte_valid = 1'b0;
        end
    end

    assign data    = shift_q;
    assign stop_ok = sync2_q;

endmodule
`default_nettype wire

// File: rtl/ikbd_host_acia.sv
`default_nettype none
// ============================================================================
//  Module      : ikbd_host_acia
//  Description : Host-side 6850-style ACIA for the keyboard controller SCI
//                link. Holds the control register, status flags, the
//                two-register bus decode and the transmitter; the receiver
//                lives in ikbd_acia_rx.
//  Ports       : mcu_clx2, mcu_rst_n - clock / async active-low reset
//                cs, rs, wr, rd      - bus select, register select, strobes
//                din / dout          - write data / combinational read data
//                irq_n               - active-low interrupt
//                rxd / txd           - serial in / serial out
//                rts_n               - request to send
//  Revision    : 1.0  initial release
// ============================================================================
module ikbd_host_acia
    import ikbd_host_acia_pkg::*;
#(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic       mcu_clx2,
    input  logic       mcu_rst_n,
    input  logic       cs,
    input  logic       rs,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n,
    input  logic       rxd,
    output logic       txd,
    output logic       rts_n
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0]       cr_q, cr_d;
    logic [7:0]       rdr_q, rdr_d;
    logic [7:0]       tdr_q, tdr_d;
    logic             rdrf_q, rdrf_d;
    logic             tdre_q, tdre_d;
    logic             fe_q, fe_d;
    logic             ovrn_q, ovrn_d;
    logic             stat_seen_q, stat_seen_d;  // status read since OVRN set
    tx_state_t        tx_state_q, tx_state_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;

    logic       wr_ctrl, wr_data, rd_stat, rd_data;
    logic       mr_q, mr_d, brk_q, tie, rie, irq, two_stop;
    logic       tx_load, tx_bit_end, tx_line;
    logic       rx_valid, rx_stop_ok;
    logic [7:0] rx_data;
    logic [7:0] sr;

    assign wr_ctrl = cs & wr & (rs == CTRL_STAT);
    assign wr_data = cs & wr & (rs == DATA);
    assign rd_stat = cs & rd & (rs == CTRL_STAT);
    assign rd_data = cs & rd & (rs == DATA);

    assign cr_d     = wr_ctrl ? din : cr_q;
    assign mr_q     = (cr_q[CR_CDS_LSB +: 2] == CDS_MASTER_RESET);
    // Master reset taken from the incoming CR value so a write of 11
    // aborts rx/tx and clears flags on the same edge that stores it.
    assign mr_d     = (cr_d[CR_CDS_LSB +: 2] == CDS_MASTER_RESET);
    assign brk_q    = (cr_q[CR_TC_LSB +: 2] == TC_BREAK);
    assign tie      = (cr_q[CR_TC_LSB +: 2] == TC_TIE_ON);
    assign rie      = cr_q[CR_RIE];
    assign two_stop = (cr_q[CR_WS_LSB +: 3] == WS_TWO_STOP);

    assign irq   = (rie & (rdrf_q | ovrn_q)) | (tie & tdre_q);
    assign irq_n = ~irq;
    assign rts_n = (cr_q[CR_TC_LSB +: 2] == TC_RTS_HIGH);

    ikbd_acia_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (mcu_clx2),
        .rst_n      (mcu_rst_n),
        .enable     (!mr_d),
        .rxd        (rxd),
        .byte_valid (rx_valid),
        .data       (rx_data),
        .stop_ok    (rx_stop_ok)
    );

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            cr_q        <= 8'h03;
            rdr_q       <= '0;
            tdr_q       <= '0;
            rdrf_q      <= 1'b0;
            tdre_q      <= 1'b1;
            fe_q        <= 1'b0;
            ovrn_q      <= 1'b0;
            stat_seen_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
        end else begin
            cr_q        <= cr_d;
            rdr_q       <= rdr_d;
            tdr_q       <= tdr_d;
            rdrf_q      <= rdrf_d;
            tdre_q      <= tdre_d;
            fe_q        <= fe_d;
            ovrn_q      <= ovrn_d;
            stat_seen_q <= stat_seen_d;
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
        end
    end

    // Receive-side status flags
    always_comb begin
        rdr_d       = rdr_q;
        rdrf_d      = rdrf_q;
        fe_d        = fe_q;
        ovrn_d      = ovrn_q;
        stat_seen_d = stat_seen_q;

        if (rd_stat && ovrn_q) begin
            stat_seen_d = 1'b1;
        end
        if (rd_data) begin
            rdrf_d = 1'b0;
            fe_d   = 1'b0;
            if (stat_seen_q) begin
                ovrn_d      = 1'b0;
                stat_seen_d = 1'b0;
            end
        end
        // Checking rdrf_d (post-read) means a read coinciding with the stop
        // sample lets the new byte in instead of flagging an overrun.
        if (rx_valid) begin
            if (!rdrf_d) begin
                rdr_d  = rx_data;
                rdrf_d = 1'b1;
                fe_d   = ~rx_stop_ok;
            end else begin
                ovrn_d      = 1'b1;
                stat_seen_d = 1'b0;
            end
        end
        if (mr_d) begin
            rdrf_d      = 1'b0;
            fe_d        = 1'b0;
            ovrn_d      = 1'b0;
            stat_seen_d = 1'b0;
        end
    end

    // Transmitter
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tdr_d      = tdr_q;
        tdre_d     = tdre_q;
        tx_load    = 1'b0;
        tx_bit_end = (tx_cnt_q == CNT_LAST);

        if (!mr_d && !brk_q) begin
            if (tx_state_q != TX_IDLE) begin
                tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
            end
            unique case (tx_state_q)
                TX_IDLE:  tx_load = !tdre_q;
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = '0;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_shift_d = {1'b1, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP1;
                        end
                    end
                end
                TX_STOP1: begin
                    if (tx_bit_end) begin
                        if (two_stop) begin
                            tx_state_d = TX_STOP2;
                        end else if (!tdre_q) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
                TX_STOP2: begin
                    if (tx_bit_end) begin
                        if (!tdre_q) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase

            // Loading straight from a stop bit gives gapless back-to-back bytes.
            if (tx_load) begin
                tx_shift_d = tdr_q;
                tdre_d     = 1'b1;
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
            end
        end else begin
            // Break or master reset abandons the frame; a pending TDR
            // survives break and goes out once it is released.
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
        end

        if (wr_data && !mr_q) begin
            tdr_d  = din;
            tdre_d = 1'b0;
        end
        if (mr_d) begin
            tdre_d = 1'b1;
        end
    end

    always_comb begin
        tx_line = 1'b1;
        unique case (tx_state_q)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shift_q[0];
            default:  tx_line = 1'b1;
        endcase
    end

    assign txd = mr_q ? 1'b1 : (brk_q ? 1'b0 : tx_line);

    always_comb begin
        sr          = '0;
        sr[SR_RDRF] = rdrf_q;
        sr[SR_TDRE] = tdre_q;
        sr[SR_DCD]  = 1'b0;
        sr[SR_CTS]  = 1'b0;
        sr[SR_FE]   = fe_q;
        sr[SR_OVRN] = ovrn_q;
        sr[SR_PE]   = 1'b0;
        sr[SR_IRQ]  = irq;
    end

    assign dout = (rs == DATA) ? rdr_q : sr;

endmodule
`default_nettype wire

// File: tb/tb_ikbd_host_acia.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ikbd_host_acia
//  Description : Directed self-checking bench for ikbd_host_acia with
//                CLKS_PER_BIT=16: reset state, rx framing/overrun/framing
//                error/false start, tx timing, back-to-back tx, break,
//                master reset and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ikbd_host_acia;

    localparam int CPB = 16;

    logic       mcu_clx2  = 1'b0;
    logic       mcu_rst_n = 1'b0;
    logic       cs        = 1'b0;
    logic       rs        = 1'b0;
    logic       wr        = 1'b0;
    logic       rd        = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       rxd       = 1'b1;
    logic [7:0] dout;
    logic       irq_n;
    logic       txd;
    logic       rts_n;

    int total  = 0;
    int passed = 0;

    ikbd_host_acia #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .mcu_clx2  (mcu_clx2),
        .mcu_rst_n (mcu_rst_n),
        .cs        (cs),
        .rs        (rs),
        .wr        (wr),
        .rd        (rd),
        .din       (din),
        .dout      (dout),
        .irq_n     (irq_n),
        .rxd       (rxd),
        .txd       (txd),
        .rts_n     (rts_n)
    );

    always #5 mcu_clx2 = ~mcu_clx2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge mcu_clx2);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic write_reg(input logic sel, input logic [7:0] value);
        cs = 1'b1; wr = 1'b1; rs = sel; din = value;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_reg(input logic sel, output logic [7:0] value);
        cs = 1'b1; rd = 1'b1; rs = sel;
        #1;
        value = dout;
        @(posedge mcu_clx2);
        #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Look at a register without a read strobe (no side effects)
    task automatic peek(input logic sel, output logic [7:0] value);
        rs = sel;
        #1;
        value = dout;
    endtask

    task automatic send_data(input logic [7:0] b);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_data(b);
        rxd = stop;
        tick(CPB);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] tx_a;
        tx_a = 8'h4B;

        // Reset state
        tick(3);
        check("reset_txd", {7'b0, txd}, 8'h01);
        check("reset_irq_n", {7'b0, irq_n}, 8'h01);
        check("reset_rts_n", {7'b0, rts_n}, 8'h00);
        peek(1'b0, v); check("reset_sr", v, 8'h02);
        peek(1'b1, v); check("reset_rdr", v, 8'h00);
        mcu_rst_n = 1'b1;
        tick(2);

        write_reg(1'b0, 8'h95);
        peek(1'b0, v); check("cr95_sr", v, 8'h02);
        check("cr95_irq_n", {7'b0, irq_n}, 8'h01);

        // Frame 0xA5, good stop bit
        send_data(8'hA5);
        rxd = 1'b1;
        tick(4);
        peek(1'b0, v); check("a5_before_stop_mid_sr", v, 8'h02);
        tick(8);
        peek(1'b0, v); check("a5_after_stop_mid_sr", v, 8'h83);
        check("a5_irq_n", {7'b0, irq_n}, 8'h00);
        tick(4);
        read_reg(1'b1, v); check("a5_data", v, 8'hA5);
        peek(1'b0, v); check("a5_sr_after_read", v, 8'h02);
        check("a5_irq_n_after_read", {7'b0, irq_n}, 8'h01);

        // Overrun: two frames without reading
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        peek(1'b0, v); check("ovrn_sr", v, 8'hA3);
        peek(1'b1, v); check("ovrn_rdr_kept", v, 8'h11);
        read_reg(1'b1, v); check("ovrn_data1", v, 8'h11);
        read_reg(1'b1, v);
        peek(1'b0, v); check("ovrn_sticky_sr", v, 8'hA2);
        read_reg(1'b0, v); check("ovrn_status_read", v, 8'hA2);
        read_reg(1'b1, v);
        peek(1'b0, v); check("ovrn_cleared_sr", v, 8'h02);

        // Framing error
        send_frame(8'h3C, 1'b0);
        rxd = 1'b1;
        tick(4);
        peek(1'b0, v); check("fe_sr", v, 8'h93);
        peek(1'b1, v); check("fe_rdr", v, 8'h3C);
        read_reg(1'b1, v);
        peek(1'b0, v); check("fe_cleared_sr", v, 8'h02);

        // False start: short glitch must not produce a byte
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(20);
        peek(1'b0, v); check("glitch_sr", v, 8'h02);
        send_frame(8'h5A, 1'b1);
        tick(4);
        peek(1'b1, v); check("after_glitch_rdr", v, 8'h5A);
        read_reg(1'b1, v);

        // Transmit with TIE
        write_reg(1'b0, 8'h35);
        peek(1'b0, v); check("tie_sr", v, 8'h82);
        check("tie_irq_n", {7'b0, irq_n}, 8'h00);
        write_reg(1'b1, tx_a);
        check("tx_idle_after_write", {7'b0, txd}, 8'h01);
        peek(1'b0, v); check("tx_tdre_low_sr", v, 8'h00);
        tick();
        check("tx_start_edge", {7'b0, txd}, 8'h00);
        peek(1'b0, v); check("tx_loaded_sr", v, 8'h82);
        check("tx_loaded_irq_n", {7'b0, irq_n}, 8'h00);
        write_reg(1'b1, 8'h96);
        peek(1'b0, v); check("tx_second_pending_sr", v, 8'h00);
        tick(7);
        check("tx_start_mid", {7'b0, txd}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick(CPB);
            check($sformatf("tx_bit%0d", i), {7'b0, txd}, {7'b0, tx_a[i]});
        end
        tick(CPB);
        check("tx_stop", {7'b0, txd}, 8'h01);
        tick(CPB);
        check("tx2_start", {7'b0, txd}, 8'h00);
        peek(1'b0, v); check("tx2_loaded_sr", v, 8'h82);
        tick(CPB);
        check("tx2_bit0", {7'b0, txd}, 8'h00);
        tick(CPB);
        check("tx2_bit1", {7'b0, txd}, 8'h01);

        // Master reset mid-frame
        write_reg(1'b0, 8'h03);
        check("mr_txd", {7'b0, txd}, 8'h01);
        peek(1'b0, v); check("mr_sr", v, 8'h02);
        check("mr_irq_n", {7'b0, irq_n}, 8'h01);

        // Break and RTS control
        write_reg(1'b0, 8'h75);
        check("break_txd", {7'b0, txd}, 8'h00);
        write_reg(1'b0, 8'h55);
        check("rts_high", {7'b0, rts_n}, 8'h01);
        check("rts_high_txd", {7'b0, txd}, 8'h01);

        // Asynchronous reset mid-receive
        write_reg(1'b0, 8'h95);
        send_frame(8'h77, 1'b1);
        tick(4);
        peek(1'b0, v); check("pre_reset_sr", v, 8'h83);
        rxd = 1'b0;
        tick(40);
        #3;
        mcu_rst_n = 1'b0;
        #1;
        peek(1'b0, v); check("async_reset_sr", v, 8'h02);
        peek(1'b1, v); check("async_reset_rdr", v, 8'h00);
        check("async_reset_irq_n", {7'b0, irq_n}, 8'h01);
        check("async_reset_txd", {7'b0, txd}, 8'h01);
        rxd = 1'b1;
        tick(2);
        mcu_rst_n = 1'b1;
        tick(3);
        peek(1'b0, v); check("post_reset_sr", v, 8'h02);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
